// File: rtl/uart_tx_stream_arbiter_if.sv
// Stream bundle between the per-requester producers, the arbiter and the UART TX input.
// The arbiter takes the slave view; the producers/UART side take the master view.
interface uart_tx_stream_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_REQ-1:0]            s_tvalid;
  logic [NUM_REQ-1:0]            s_tready;
  logic [NUM_REQ*LEN_WIDTH-1:0]  s_len;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tvalid;
  logic                          m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_len, m_tready,
    output s_tready, m_tdata, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_len, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/uart_tx_stream_arbiter.sv
// Frame-based round-robin arbiter sharing one UART TX byte stream between NUM_REQ producers.
// A granted requester owns the stream until its s_len+1 bytes have been handed over.
module uart_tx_stream_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  uart_tx_stream_arbiter_if.slave bus,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [IDX_W-1:0]     last_reg, last_next;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;

  logic                  active;
  logic                  hs;
  logic                  req_any;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W:0]        cand;
  logic [DATA_WIDTH-1:0] data_masked [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_or;
  logic [NUM_REQ-1:0]    ready_vec;

  // Outputs are forced quiet while reset is held so the UART never sees a stray byte.
  assign active = (state_reg == BURST) && !areset;

  // Round-robin search starting one past the previous owner, wrapping modulo NUM_REQ.
  always_comb begin
    req_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!req_any && bus.s_tvalid[cand[IDX_W-1:0]]) begin
        req_any = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_masked[gi] = grant_reg[gi] ? bus.s_tdata[gi*DATA_WIDTH +: DATA_WIDTH]
                                             : '0;
      assign ready_vec[gi]   = active & grant_reg[gi] & bus.m_tready;
    end
  endgenerate

  // grant_reg is one-hot, so an OR of the masked slices is the data mux.
  always_comb begin
    data_or = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_or = data_or | data_masked[i];
    end
  end

  assign bus.m_tdata  = active ? data_or : '0;
  assign bus.m_tvalid = active && |(bus.s_tvalid & grant_reg);
  assign bus.s_tready = ready_vec;
  assign hs           = bus.m_tvalid && bus.m_tready;
  assign grant        = grant_reg;
  assign busy         = (state_reg == BURST);

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          state_next = BURST;
          grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          idx_next   = win_idx;
          cnt_next   = bus.s_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      BURST: begin
        if (hs) begin
          // cnt holds bytes remaining after this one, so zero marks the final byte.
          if (cnt_reg == '0) begin
            state_next = IDLE;
            grant_next = '0;
            last_next  = idx_reg;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      idx_reg   <= '0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end
endmodule
